// File: rtl/jk_flip_flop.sv
// rtl/jk_flip_flop.sv - WIDTH independent JK cells with async active-high reset and preset
// Reset dominates preset, preset dominates the clocked JK update.
module jk_flip_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             rst,
  input  logic             pst,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             pst_set;

  // Preset is gated by reset so that dropping rst while pst is still high
  // produces a rising edge that loads all ones without waiting for clk.
  assign pst_set = pst & ~rst;

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({J[i], K[i]})
        2'b00:   q_d[i] = q_q[i];
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        default: q_d[i] = ~q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst or posedge pst_set) begin
    if (rst) begin
      q_q <= '0;
    end else if (pst_set) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// tb/tb_jk_flip_flop.sv - self-checking bench for jk_flip_flop (WIDTH=1 and WIDTH=4)
module tb_jk_flip_flop;

  typedef struct {
    logic j;
    logic k;
    logic exp_q;
  } vec_t;

  logic       clk;
  logic       j1, k1, rst1, pst1;
  logic       q1, qb1;
  logic [3:0] j4, k4, q4, qb4;
  logic       rst4, pst4;

  int nchecks;
  int nerrors;

  jk_flip_flop #(.WIDTH(1)) u_dut1 (
    .clk(clk), .J(j1), .K(k1), .rst(rst1), .pst(pst1), .Q(q1), .Q_bar(qb1)
  );

  jk_flip_flop #(.WIDTH(4)) u_dut4 (
    .clk(clk), .J(j4), .K(k4), .rst(rst4), .pst(pst4), .Q(q4), .Q_bar(qb4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic [3:0] exp);
    check({name, "_q"},    {3'b000, q1},  exp);
    check({name, "_qbar"}, {3'b000, qb1}, {3'b000, ~exp[0]});
  endtask

  task automatic check4(input string name, input logic [3:0] exp);
    check({name, "_q"},    q4,  exp);
    check({name, "_qbar"}, qb4, ~exp);
  endtask

  // Reference: JK truth table applied bit by bit.
  function automatic logic [3:0] jk_model(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
    logic [3:0] n;
    for (int b = 0; b < 4; b++) begin
      if (j[b] && k[b])      n[b] = !q[b];
      else if (j[b])         n[b] = 1'b1;
      else if (k[b])         n[b] = 1'b0;
      else                   n[b] = q[b];
    end
    return n;
  endfunction

  vec_t vecs[8];

  initial begin
    logic [3:0] model;
    logic [3:0] jv, kv;
    int         mode;

    nchecks = 0;
    nerrors = 0;
    vecs[0] = '{1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0};

    j1 = 1'b0; k1 = 1'b0; rst1 = 1'b0; pst1 = 1'b0;
    j4 = 4'h0; k4 = 4'h0; rst4 = 1'b0; pst4 = 1'b0;

    // Async reset between edges, then release
    #12 rst1 = 1'b1;
    #1  check1("async_rst", 4'h0);
    #9  rst1 = 1'b0;
    #1  check1("rst_release", 4'h0);
    pst1 = 1'b1;
    #1  check1("async_pst", 4'h1);
    #10 pst1 = 1'b0;

    // Table: set, hold, reset, toggle x3, hold, reset (t=34 onward)
    for (int i = 0; i < 8; i++) begin
      j1 = vecs[i].j;
      k1 = vecs[i].k;
      if (i == 0) #2;
      else #10;
      check1($sformatf("vec%0d", i), {3'b000, vecs[i].exp_q});
    end

    // Priority: both asserted, then rst dropped with pst held, J=K=1 throughout
    j1 = 1'b1; k1 = 1'b1; rst1 = 1'b1; pst1 = 1'b1;
    #1  check1("both_asserted", 4'h0);
    #10 check1("both_no_toggle", 4'h0);
    rst1 = 1'b0;
    #1  check1("rst_drop_pst_held", 4'h1);
    #8  check1("pst_no_toggle", 4'h1);
    pst1 = 1'b0;
    #10 check1("first_edge_after_pst", 4'h0);

    // WIDTH=4 directed per-bit case (t=136)
    rst4 = 1'b1;
    #1  check4("w4_rst", 4'h0);
    rst4 = 1'b0; j4 = 4'b0011; k4 = 4'b0000;
    #9  check4("w4_load", 4'b0011);
    j4 = 4'b1010; k4 = 4'b0110;
    #10 check4("w4_mixed", 4'b1001);
    pst4 = 1'b1;
    #1  check4("w4_pst", 4'hF);
    #1  pst4 = 1'b0;
    model = 4'hF;
    #8;

    // Random JK with occasional async pulses between edges (start at edge+1)
    for (int i = 0; i < 300; i++) begin
      jv = 4'($urandom);
      kv = 4'($urandom);
      j4 = jv;
      k4 = kv;
      mode = $urandom_range(0, 7);
      #1;
      if (mode == 0) rst4 = 1'b1;
      if (mode == 1) pst4 = 1'b1;
      if (mode == 2) begin rst4 = 1'b1; pst4 = 1'b1; end
      #1;
      if (mode < 3) begin
        model = (mode == 1) ? 4'hF : 4'h0;
        check4($sformatf("rnd_async%0d", i), model);
      end
      #1;
      rst4 = 1'b0;
      pst4 = 1'b0;
      #7;
      model = jk_model(model, jv, kv);
      check4($sformatf("rnd%0d", i), model);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
